// File: rtl/updown_counter_ctl_if.sv
// updown_counter_ctl_if: control, load and status signals of the up/down counter
interface updown_counter_ctl_if #(
  parameter int WIDTH = 7
);
  logic             start;
  logic             stop;
  logic             UpOrDown;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Count;
  logic             tick;
  logic             terminal;
  logic             running;
  modport master (
    output start, stop, UpOrDown, load, load_value,
    input  Count, tick, terminal, running
  );
  modport slave (
    input  start, stop, UpOrDown, load, load_value,
    output Count, tick, terminal, running
  );
endinterface

// File: rtl/updown_counter_ctl.sv
// updown_counter_ctl: prescaled up/down counter with load, wrap/saturate bounds and start/stop run FSM
module updown_counter_ctl #(
  parameter int WIDTH     = 7,
  parameter int MAX_COUNT = 99,
  parameter int PRESCALE  = 25000000,
  parameter bit SATURATE  = 1'b0
) (
  input logic                 Clk,
  input logic                 reset,
  updown_counter_ctl_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_COUNT);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t           state, state_nxt;
  logic [PW-1:0]    pre;
  logic [WIDTH-1:0] count, count_nxt, load_clamped;
  logic             tick_q, term_q, run_q;
  logic             adv, hit, at_bound;
  // Next state: stop wins over start, and IDLE is only left through start
  always_comb begin
    state_nxt = state;
    state_nxt = bus.stop ? (state == IDLE ? IDLE : HOLD) : bus.start ? RUN : state;
  end
  // Prescaler advance, tick detection and the bounded next count; the cycle that sees stop already counts as held
  always_comb begin
    adv          = state == RUN && !bus.stop;
    hit          = adv && pre == PRE_LAST;
    at_bound     = bus.UpOrDown ? count == MAXC : count == '0;
    load_clamped = bus.load_value > MAXC ? MAXC : bus.load_value;
    count_nxt    = bus.UpOrDown ? (at_bound ? (SATURATE ? MAXC : '0) : count + 1'b1)
                                : (at_bound ? (SATURATE ? '0 : MAXC) : count - 1'b1);
  end
  // State, prescaler, count and registered pulses; a load cancels a coincident tick
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state  <= IDLE;
      pre    <= '0;
      count  <= '0;
      tick_q <= 1'b0;
      term_q <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      run_q  <= state_nxt == RUN;
      tick_q <= hit && !bus.load;
      term_q <= hit && !bus.load && at_bound;
      pre    <= (bus.load || hit) ? '0 : adv ? pre + 1'b1 : pre;
      count  <= bus.load ? load_clamped : hit ? count_nxt : count;
    end
  end
  assign bus.Count    = count;
  assign bus.tick     = tick_q;
  assign bus.terminal = term_q;
  assign bus.running  = run_q;
endmodule

// File: tb/tb_updown_counter_ctl.sv
// tb_updown_counter_ctl: vector table, directed corner cases and random run against a reference model
module tb_updown_counter_ctl;
  localparam int W = 7, MAXC = 99, P = 4;
  logic Clk = 0, reset = 0, start = 0, stop = 0, ud = 0, load = 0;
  logic [W-1:0] lv = '0;
  int n_chk = 0, n_fail = 0;
  updown_counter_ctl_if #(.WIDTH(W)) bw ();
  updown_counter_ctl_if #(.WIDTH(W)) bs ();
  assign bw.start = start;
  assign bw.stop = stop;
  assign bw.UpOrDown = ud;
  assign bw.load = load;
  assign bw.load_value = lv;
  assign bs.start = start;
  assign bs.stop = stop;
  assign bs.UpOrDown = ud;
  assign bs.load = load;
  assign bs.load_value = lv;
  updown_counter_ctl #(.WIDTH(W), .MAX_COUNT(MAXC), .PRESCALE(P), .SATURATE(1'b0)) dut_w (
    .Clk(Clk), .reset(reset), .bus(bw.slave));
  updown_counter_ctl #(.WIDTH(W), .MAX_COUNT(MAXC), .PRESCALE(P), .SATURATE(1'b1)) dut_s (
    .Clk(Clk), .reset(reset), .bus(bs.slave));
  always #5 Clk = ~Clk;
  int m_mode = 0;
  int m_cyc = 0;
  int m_cnt[2] = '{0, 0};
  int m_tick = 0;
  int m_term[2] = '{0, 0};
  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction
  task automatic model_edge();
    int fire;
    if (!reset) begin
      m_mode = 0;
      m_cyc = 0;
      m_cnt = '{0, 0};
      m_tick = 0;
      m_term = '{0, 0};
    end else begin
      fire = (m_mode == 1 && !stop && m_cyc == P - 1) ? 1 : 0;
      m_tick = fire && !load ? 1 : 0;
      for (int s = 0; s < 2; s++) begin
        m_term[s] = (m_tick == 1 && (ud ? m_cnt[s] == MAXC : m_cnt[s] == 0)) ? 1 : 0;
        if (load) m_cnt[s] = int'(lv) > MAXC ? MAXC : int'(lv);
        else if (m_tick == 1) begin
          if (s == 0) m_cnt[s] = ud ? (m_cnt[s] + 1) % (MAXC + 1) : (m_cnt[s] + MAXC) % (MAXC + 1);
          else m_cnt[s] = ud ? (m_cnt[s] < MAXC ? m_cnt[s] + 1 : MAXC) : (m_cnt[s] > 0 ? m_cnt[s] - 1 : 0);
        end
      end
      if (load || fire == 1) m_cyc = 0;
      else if (m_mode == 1 && !stop) m_cyc = m_cyc + 1;
      if (stop) m_mode = m_mode == 0 ? 0 : 2;
      else if (start) m_mode = 1;
    end
  endtask
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    chk("model count wrap", bw.Count, m_cnt[0]);
    chk("model count sat", bs.Count, m_cnt[1]);
    chk("model tick wrap", bw.tick, m_tick);
    chk("model tick sat", bs.tick, m_tick);
    chk("model terminal wrap", bw.terminal, m_term[0]);
    chk("model terminal sat", bs.terminal, m_term[1]);
    chk("model running wrap", bw.running, m_mode == 1 ? 1 : 0);
    chk("model running sat", bs.running, m_mode == 1 ? 1 : 0);
  endtask
  task automatic wait_tick(string name);
    int got;
    got = 0;
    for (int i = 0; i < 4 * P && got == 0; i++) begin
      step();
      got = bw.tick;
    end
    chk({name, " tick seen"}, got, 1);
  endtask
  typedef struct {
    logic rst_n, st, sp, dir, ld;
    logic [W-1:0] val;
    int cnt, tck, trm, run;
  } vec_t;
  function automatic vec_t v(logic rst_n, logic st, logic dir, logic ld, int val, int cnt, int tck, int trm, int run);
    vec_t r;
    r.rst_n = rst_n;
    r.st = st;
    r.sp = 1'b0;
    r.dir = dir;
    r.ld = ld;
    r.val = W'(val);
    r.cnt = cnt;
    r.tck = tck;
    r.trm = trm;
    r.run = run;
    return r;
  endfunction
  initial begin
    vec_t tbl[$];
    int cw, any_tick;
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 1, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 2, 1, 0, 1));
    tbl.push_back(v(1, 1, 1, 1, 98, 98, 0, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 0, 98, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 99, 1, 0, 1));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 1, 1, 0, 0, 99, 0, 0, 1));
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 1, 1, 1));
    tbl.push_back(v(1, 1, 1, 1, 120, 99, 0, 0, 1));
    foreach (tbl[i]) begin
      reset = tbl[i].rst_n;
      start = tbl[i].st;
      stop = tbl[i].sp;
      ud = tbl[i].dir;
      load = tbl[i].ld;
      lv = tbl[i].val;
      step();
      chk($sformatf("vec%0d count", i), bw.Count, tbl[i].cnt);
      chk($sformatf("vec%0d tick", i), bw.tick, tbl[i].tck);
      chk($sformatf("vec%0d terminal", i), bw.terminal, tbl[i].trm);
      chk($sformatf("vec%0d running", i), bw.running, tbl[i].run);
    end
    load = 1;
    lv = '0;
    step();
    load = 0;
    ud = 0;
    wait_tick("down wrap");
    chk("down wrap count", bw.Count, 99);
    chk("down wrap terminal", bw.terminal, 1);
    chk("down sat count", bs.Count, 0);
    chk("down sat terminal", bs.terminal, 1);
    wait_tick("down again");
    chk("down sat hold count", bs.Count, 0);
    chk("down sat hold terminal", bs.terminal, 1);
    chk("down wrap next count", bw.Count, 98);
    chk("down wrap next terminal", bw.terminal, 0);
    ud = 1;
    wait_tick("pre stop");
    step();
    step();
    cw = bw.Count;
    stop = 1;
    start = 0;
    step();
    chk("stop running", bw.running, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold count frozen", bw.Count, cw);
      chk("hold running", bw.running, 0);
    end
    start = 1;
    step();
    chk("start+stop stays hold", bw.running, 0);
    stop = 0;
    step();
    chk("resume running", bw.running, 1);
    chk("resume tick0", bw.tick, 0);
    step();
    chk("resume tick1", bw.tick, 0);
    step();
    chk("resume tick2", bw.tick, 1);
    for (int i = 0; i < 3; i++) step();
    load = 1;
    lv = W'(10);
    step();
    chk("load on tick count", bw.Count, 10);
    chk("load on tick tick", bw.tick, 0);
    chk("load on tick terminal", bw.terminal, 0);
    load = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post load no tick", bw.tick, 0);
    end
    step();
    chk("post load tick", bw.tick, 1);
    chk("post load count", bw.Count, 11);
    load = 1;
    lv = W'(57);
    step();
    load = 0;
    chk("preload 57", bw.Count, 57);
    step();
    reset = 0;
    step();
    chk("midrun reset count", bw.Count, 0);
    chk("midrun reset running", bw.running, 0);
    chk("midrun reset tick", bw.tick, 0);
    reset = 1;
    start = 0;
    any_tick = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_tick |= bw.tick;
    end
    chk("idle after reset no tick", any_tick, 0);
    chk("idle after reset count", bw.Count, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(99) != 0;
      start = $urandom_range(3) == 0;
      stop = $urandom_range(7) == 0;
      load = $urandom_range(15) == 0;
      lv = W'($urandom_range(127));
      if ($urandom_range(9) == 0) ud = ~ud;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/updown_counter_ctl.md
Name: updown_counter_ctl

Overview:
- Parametrised successor of the team's up/down display counter.
- Generalised in count width, modulus and tick rate; adds a programmable load value, a wrap-or-saturate mode, a start/stop run FSM and a terminal-count pulse.
- Generates a one-cycle tick enable internally, so the design has no derived clocks. Everything is clocked on Clk.
- Drives the count shown on the board's display digits. Terminal pulse cascades to further counters.

Parameters:
- WIDTH, 7, count width in bits.
- MAX_COUNT, 99, highest count value. Must be less than 2^WIDTH.
- PRESCALE, 25000000, Clk cycles per count tick. Must be 1 or more.
- SATURATE, 0: 0 = wrap at the bounds, 1 = hold at the bounds.

Ports:
- Clk  in  1  system clock. All logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  level. Requests the RUN state.
- stop  in  1  level. Requests the HOLD state. Has priority over start.
- UpOrDown  in  1  1 = count up, 0 = count down. Sampled on each tick.
- load  in  1  synchronous load strobe.
- load_value  in  WIDTH  value written on load.
- Count  out  WIDTH  current count.
- tick  out  1  one-cycle count-enable pulse.
- terminal  out  1  one-cycle pulse when a tick hits a bound.
- running  out  1  high while the FSM is in RUN.

Behaviour:
- Reset is sampled on the rising edge of Clk while reset=0:
  - FSM = IDLE; Count = 0; prescaler = 0.
  - tick = 0; terminal = 0; running = 0.
  - Reset overrides every other input, including in mid-run.
- FSM states are IDLE, RUN and HOLD:
  - IDLE: start=1 and stop=0 -> RUN.
  - RUN: stop=1 -> HOLD.
  - HOLD: start=1 and stop=0 -> RUN.
  - start=1 and stop=1 together -> HOLD from any state other than IDLE. IDLE stays IDLE.
  - There is no other path back to IDLE except reset.
- running is a registered output, equal to 1 exactly when the state is RUN.
- Prescaler:
  - Width is clog2(PRESCALE), minimum 1 bit.
  - Increments only in RUN. Frozen in HOLD. Held at 0 in IDLE.
  - When it equals PRESCALE-1 in RUN: tick=1 on the next cycle and the prescaler returns to 0.
  - The first tick comes PRESCALE cycles after entering RUN from IDLE.
  - PRESCALE=1 gives a tick on every RUN cycle.
- Count update on tick with load=0:
  - Up, Count < MAX_COUNT: Count+1.
  - Up, Count = MAX_COUNT: goes to 0 if SATURATE=0, otherwise holds MAX_COUNT. terminal=1 for that cycle in both modes.
  - Down, Count > 0: Count-1.
  - Down, Count = 0: goes to MAX_COUNT if SATURATE=0, otherwise holds 0. terminal=1 for that cycle in both modes.
  - Count never leaves the range 0..MAX_COUNT.
- Load:
  - Accepted in any state except reset, including IDLE and HOLD.
  - Count = min(load_value, MAX_COUNT) on the next edge.
  - Prescaler is cleared to 0.
  - Load beats a tick in the same cycle: that tick is dropped and terminal=0.
- The direction input may change at any time. Only its value on the tick cycle matters.
- Latency: tick and terminal are registered and align with the cycle on which Count changes. Count is valid one cycle after a tick or load edge.
- terminal is never high on two consecutive cycles unless PRESCALE=1.

Test Plan:
1. Parameters WIDTH=7, MAX_COUNT=99, PRESCALE=4, SATURATE=0:
   - Stimulus: reset low 2 cycles, release, start=1, UpOrDown=1.
   - Required: first tick at cycle 4 of RUN; Count reads 0,1,2… once every 4 cycles.
   - Required: running=1 from the cycle after start.
2. Load then wrap upward:
   - Stimulus: load=1 with load_value=98, then run up.
   - Required: Count 98 -> 99 -> 0; terminal=1 only on the 99->0 tick.
   - Then load_value=120: required Count=99 (clamped).
3. Wrap downward, then saturate:
   - Stimulus: Count=0, UpOrDown=0, tick.
   - Required: Count=99 and terminal=1.
   - Repeat with SATURATE=1: required Count stays 0 and terminal=1 on every tick at 0.
4. Stop and restart:
   - Stimulus: stop=1 at prescaler=2, hold 10 cycles, then start=1.
   - Required: Count frozen and running=0 during the hold; next tick exactly 2 cycles after RUN resumes.
   - Stimulus: start=1 and stop=1 together. Required: state stays HOLD.
5. Load and tick in the same cycle:
   - Stimulus: load asserted with load_value=10 on the tick cycle.
   - Required: Count=10, terminal=0, next tick PRESCALE cycles later.
6. Reset in mid-run:
   - Stimulus: reset=0 while Count=57 in RUN.
   - Required: next edge gives Count=0, FSM IDLE, running=0, tick=0.
   - Required: no ticks afterwards until start.
